// File: rtl/branch_target_predictor_pkg.sv
// Shared types and counter-init helpers for the branch target predictor.
// Entry fields are sized for the widest legal configuration; unused upper bits stay zero.
package branch_target_predictor_pkg;

   localparam int CTR_MAX_BITS = 4;

   typedef struct packed {
      logic                    valid;
      logic [31:0]             tag;
      logic [31:0]             target;
      logic [CTR_MAX_BITS-1:0] ctr;
   } btb_entry_t;

   function automatic logic [CTR_MAX_BITS-1:0] ctr_weak_nt(input int bits);
      return CTR_MAX_BITS'((1 << (bits - 1)) - 1);
   endfunction

   function automatic logic [CTR_MAX_BITS-1:0] ctr_weak_t(input int bits);
      return CTR_MAX_BITS'(1 << (bits - 1));
   endfunction

endpackage

// File: rtl/branch_target_predictor_if.sv
// Fetch lookup, resolve-stage update and perf signals of the branch target predictor.
interface branch_target_predictor_if #(
   parameter int PERF_BITS = 32
);
   logic                 en;
   logic [31:0]          lookup_pc;
   logic                 pred_taken;
   logic [31:0]          pred_target;
   logic                 upd_valid;
   logic [31:0]          upd_pc;
   logic                 upd_taken;
   logic [31:0]          upd_target;
   logic                 upd_is_jump;
   logic                 upd_mispredict;
   logic                 flush_all;
   logic [PERF_BITS-1:0] mispredict_cnt;

   modport master (
      output en, lookup_pc, upd_valid, upd_pc, upd_taken, upd_target,
             upd_is_jump, upd_mispredict, flush_all,
      input  pred_taken, pred_target, mispredict_cnt
   );

   modport slave (
      input  en, lookup_pc, upd_valid, upd_pc, upd_taken, upd_target,
             upd_is_jump, upd_mispredict, flush_all,
      output pred_taken, pred_target, mispredict_cnt
   );
endinterface

// File: rtl/branch_target_predictor_sat_counter.sv
// Next-value logic for a saturating counter; priority is force_max, load, inc, dec.
module branch_target_predictor_sat_counter #(
   parameter int W = 2
) (
   input  logic [W-1:0] cur_i,
   input  logic         inc_i,
   input  logic         dec_i,
   input  logic         force_max_i,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   output logic [W-1:0] nxt_o
);

   always_comb begin
      nxt_o = cur_i;
      if (force_max_i) begin
         nxt_o = '1;
      end else if (load_i) begin
         nxt_o = load_val_i;
      end else if (inc_i) begin
         if (cur_i != '1) nxt_o = cur_i + W'(1);
      end else if (dec_i) begin
         if (cur_i != '0) nxt_o = cur_i - W'(1);
      end
   end

endmodule

// File: rtl/branch_target_predictor.sv
// Direct-mapped BTB with per-entry saturating direction counters and a saturating
// misprediction counter. Lookup is combinational and sees pre-update state.
module branch_target_predictor
   import branch_target_predictor_pkg::*;
#(
   parameter int ENTRIES   = 16,
   parameter int CTR_BITS  = 2,
   parameter int PERF_BITS = 32
) (
   input logic                     CLK,
   input logic                     nRST,
   branch_target_predictor_if.slave bus
);

   localparam int IDX = $clog2(ENTRIES);
   localparam logic [CTR_BITS-1:0] CTR_WNT = CTR_BITS'(ctr_weak_nt(CTR_BITS));
   localparam logic [CTR_BITS-1:0] CTR_WT  = CTR_BITS'(ctr_weak_t(CTR_BITS));
   localparam btb_entry_t ENTRY_RST = '{valid: 1'b0, tag: 32'h0, target: 32'h0,
                                        ctr: CTR_MAX_BITS'(CTR_WNT)};

   btb_entry_t tbl_q [ENTRIES];
   btb_entry_t tbl_d [ENTRIES];
   logic [PERF_BITS-1:0] perf_q, perf_d;

   logic [IDX-1:0]      lu_idx, up_idx;
   logic [31:0]         lu_tag, up_tag;
   btb_entry_t          lu_e, up_e;
   logic                lu_hit, up_hit, do_upd, upd_redirect;
   logic [CTR_BITS-1:0] ctr_nxt;
   logic [1:0]          unused_upd_lsb;

   assign unused_upd_lsb = bus.upd_pc[1:0];

   // Tags are kept right-justified so the full 32-bit field can be compared.
   assign lu_idx = bus.lookup_pc[IDX+1:2];
   assign lu_tag = 32'(bus.lookup_pc >> (IDX + 2));
   assign up_idx = bus.upd_pc[IDX+1:2];
   assign up_tag = 32'(bus.upd_pc >> (IDX + 2));

   assign lu_e   = tbl_q[lu_idx];
   assign lu_hit = lu_e.valid && (lu_e.tag == lu_tag);
   assign bus.pred_taken  = lu_hit && lu_e.ctr[CTR_BITS-1];
   assign bus.pred_target = bus.pred_taken ? lu_e.target : bus.lookup_pc + 32'd4;

   assign up_e         = tbl_q[up_idx];
   assign up_hit       = up_e.valid && (up_e.tag == up_tag);
   assign do_upd       = bus.upd_valid && bus.en;
   assign upd_redirect = bus.upd_taken || bus.upd_is_jump;

   branch_target_predictor_sat_counter #(.W(CTR_BITS)) u_dir_ctr (
      .cur_i       (up_e.ctr[CTR_BITS-1:0]),
      .inc_i       (bus.upd_taken && !bus.upd_is_jump),
      .dec_i       (!bus.upd_taken && !bus.upd_is_jump),
      .force_max_i (bus.upd_is_jump),
      .load_i      (!up_hit),
      .load_val_i  (CTR_WT),
      .nxt_o       (ctr_nxt)
   );

   branch_target_predictor_sat_counter #(.W(PERF_BITS)) u_perf_ctr (
      .cur_i       (perf_q),
      .inc_i       (do_upd && bus.upd_mispredict),
      .dec_i       (1'b0),
      .force_max_i (1'b0),
      .load_i      (1'b0),
      .load_val_i  ('0),
      .nxt_o       (perf_d)
   );

   // Flush only drops valid bits; counters and targets survive for reallocation.
   always_comb begin
      tbl_d = tbl_q;
      if (bus.en && bus.flush_all) begin
         for (int i = 0; i < ENTRIES; i++) tbl_d[i].valid = 1'b0;
      end else if (do_upd) begin
         if (up_hit) begin
            tbl_d[up_idx].ctr = CTR_MAX_BITS'(ctr_nxt);
            if (upd_redirect) tbl_d[up_idx].target = bus.upd_target;
         end else if (upd_redirect) begin
            tbl_d[up_idx] = '{valid: 1'b1, tag: up_tag, target: bus.upd_target,
                              ctr: CTR_MAX_BITS'(ctr_nxt)};
         end
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         for (int i = 0; i < ENTRIES; i++) tbl_q[i] <= ENTRY_RST;
         perf_q <= '0;
      end else begin
         tbl_q  <= tbl_d;
         perf_q <= perf_d;
      end
   end

   assign bus.mispredict_cnt = perf_q;

endmodule

// File: tb/tb_branch_target_predictor.sv
// Directed bench: a default instance plus a PERF_BITS=2 instance sharing all inputs.
module tb_branch_target_predictor;

   logic CLK = 1'b0;
   logic nRST;
   int   n_assert = 0;
   int   n_fail   = 0;

   branch_target_predictor_if #(.PERF_BITS(32)) bus0 ();
   branch_target_predictor_if #(.PERF_BITS(2))  bus1 ();

   assign bus1.en             = bus0.en;
   assign bus1.lookup_pc      = bus0.lookup_pc;
   assign bus1.upd_valid      = bus0.upd_valid;
   assign bus1.upd_pc         = bus0.upd_pc;
   assign bus1.upd_taken      = bus0.upd_taken;
   assign bus1.upd_target     = bus0.upd_target;
   assign bus1.upd_is_jump    = bus0.upd_is_jump;
   assign bus1.upd_mispredict = bus0.upd_mispredict;
   assign bus1.flush_all      = bus0.flush_all;

   branch_target_predictor #(.ENTRIES(16), .CTR_BITS(2), .PERF_BITS(32)) dut (
      .CLK  (CLK),
      .nRST (nRST),
      .bus  (bus0)
   );

   branch_target_predictor #(.ENTRIES(16), .CTR_BITS(2), .PERF_BITS(2)) dut_p2 (
      .CLK  (CLK),
      .nRST (nRST),
      .bus  (bus1)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic look(input logic [31:0] pc, input string tag,
                       input logic exp_taken, input logic [31:0] exp_target);
      bus0.lookup_pc = pc;
      #1;
      chk({tag, "_taken"}, {31'h0, bus0.pred_taken}, {31'h0, exp_taken});
      chk({tag, "_target"}, bus0.pred_target, exp_target);
   endtask

   task automatic upd(input logic [31:0] pc, input logic taken, input logic [31:0] target,
                      input logic jump, input logic mis);
      bus0.en             = 1'b1;
      bus0.upd_valid      = 1'b1;
      bus0.upd_pc         = pc;
      bus0.upd_taken      = taken;
      bus0.upd_target     = target;
      bus0.upd_is_jump    = jump;
      bus0.upd_mispredict = mis;
      @(posedge CLK);
      #1;
      bus0.upd_valid      = 1'b0;
      bus0.upd_mispredict = 1'b0;
   endtask

   initial begin
      nRST                = 1'b0;
      bus0.en             = 1'b1;
      bus0.lookup_pc      = 32'h0000_0040;
      bus0.upd_valid      = 1'b0;
      bus0.upd_pc         = 32'h0;
      bus0.upd_taken      = 1'b0;
      bus0.upd_target     = 32'h0;
      bus0.upd_is_jump    = 1'b0;
      bus0.upd_mispredict = 1'b0;
      bus0.flush_all      = 1'b0;

      #2;
      look(32'h0000_0040, "rst", 1'b0, 32'h0000_0044);
      chk("rst_cnt", bus0.mispredict_cnt, 32'd0);
      chk("rst_cnt_p2", {30'h0, bus1.mispredict_cnt}, 32'd0);
      @(posedge CLK);
      #1 nRST = 1'b1;
      @(posedge CLK);
      #1;

      // allocate, then train down with two not-taken outcomes
      upd(32'h40, 1'b1, 32'h100, 1'b0, 1'b0);
      look(32'h40, "alloc", 1'b1, 32'h100);
      upd(32'h40, 1'b0, 32'h0, 1'b0, 1'b0);
      upd(32'h40, 1'b0, 32'h0, 1'b0, 1'b0);
      look(32'h40, "train_nt", 1'b0, 32'h44);

      // 0x80 shares index 0 with 0x40 and replaces it
      upd(32'h80, 1'b1, 32'h200, 1'b0, 1'b0);
      look(32'h40, "alias_old", 1'b0, 32'h44);
      look(32'h80, "alias_new", 1'b1, 32'h200);

      // 5 taken saturate at 11; one not-taken leaves 10, another gives 01
      for (int i = 0; i < 5; i++) upd(32'h40, 1'b1, 32'h100, 1'b0, 1'b0);
      upd(32'h40, 1'b0, 32'h0, 1'b0, 1'b0);
      look(32'h40, "sat_one_nt", 1'b1, 32'h100);
      look(32'h80, "sat_alias_gone", 1'b0, 32'h84);
      upd(32'h40, 1'b0, 32'h0, 1'b0, 1'b0);
      look(32'h40, "sat_two_nt", 1'b0, 32'h44);

      // jump allocates at all-ones, so one not-taken still predicts taken
      look(32'h1004, "jmp_before", 1'b0, 32'h1008);
      upd(32'h1004, 1'b1, 32'h2000, 1'b1, 1'b0);
      look(32'h1004, "jmp_alloc", 1'b1, 32'h2000);
      upd(32'h1004, 1'b0, 32'h0, 1'b0, 1'b0);
      look(32'h1004, "jmp_then_nt", 1'b1, 32'h2000);

      // same-cycle update/lookup: old prediction now, new one after the edge
      bus0.upd_valid  = 1'b1;
      bus0.upd_pc     = 32'h40;
      bus0.upd_taken  = 1'b1;
      bus0.upd_target = 32'h300;
      bus0.upd_is_jump = 1'b0;
      look(32'h40, "same_cyc_pre", 1'b0, 32'h44);
      @(posedge CLK);
      #1 bus0.upd_valid = 1'b0;
      look(32'h40, "same_cyc_post", 1'b1, 32'h300);

      // flush wins over a simultaneous update
      bus0.flush_all = 1'b1;
      upd(32'h1004, 1'b1, 32'h5000, 1'b1, 1'b0);
      bus0.flush_all = 1'b0;
      look(32'h1004, "flush_upd", 1'b0, 32'h1008);
      look(32'h40, "flush_other", 1'b0, 32'h44);

      // en low: update and mispredict are ignored
      bus0.en             = 1'b0;
      bus0.upd_valid      = 1'b1;
      bus0.upd_pc         = 32'h40;
      bus0.upd_taken      = 1'b1;
      bus0.upd_target     = 32'h700;
      bus0.upd_is_jump    = 1'b0;
      bus0.upd_mispredict = 1'b1;
      @(posedge CLK);
      #1;
      bus0.upd_valid      = 1'b0;
      bus0.upd_mispredict = 1'b0;
      bus0.en             = 1'b1;
      look(32'h40, "en_low", 1'b0, 32'h44);
      chk("en_low_cnt", bus0.mispredict_cnt, 32'd0);

      // not-taken misses never allocate; mispredict counter saturates at 3 for 2 bits
      for (int i = 0; i < 3; i++) upd(32'h3000, 1'b0, 32'h0, 1'b0, 1'b1);
      chk("cnt3", bus0.mispredict_cnt, 32'd3);
      chk("cnt3_p2", {30'h0, bus1.mispredict_cnt}, 32'd3);
      for (int i = 0; i < 2; i++) upd(32'h3000, 1'b0, 32'h0, 1'b0, 1'b1);
      chk("cnt5", bus0.mispredict_cnt, 32'd5);
      chk("cnt5_p2", {30'h0, bus1.mispredict_cnt}, 32'd3);
      look(32'h3000, "nt_no_alloc", 1'b0, 32'h3004);
      look(32'hFFFF_FFFC, "pc_wrap", 1'b0, 32'h0000_0000);

      // asynchronous reset mid-operation
      upd(32'h40, 1'b1, 32'h900, 1'b0, 1'b0);
      look(32'h40, "pre_rst", 1'b1, 32'h900);
      #2 nRST = 1'b0;
      look(32'h40, "mid_rst", 1'b0, 32'h44);
      chk("mid_rst_cnt", bus0.mispredict_cnt, 32'd0);
      chk("mid_rst_cnt_p2", {30'h0, bus1.mispredict_cnt}, 32'd0);
      #3 nRST = 1'b1;
      @(posedge CLK);
      #1;
      look(32'h40, "post_rst", 1'b0, 32'h44);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
